// File: rtl/ram_byte_reader_if.sv
// ram_byte_reader_if: bundles the command, RAM read port and byte-stream
// signals of ram_byte_reader.
//   start/base_addr/len : burst command from the controller
//   busy/done           : burst status back to the controller
//   ram_addr/ram_data   : asynchronous RAM read port (data combinational from addr)
//   m_data/m_valid/m_ready/m_last : valid/ready byte stream to the consumer
// Modports: master = reader side (drives status, RAM address, stream);
//           slave  = surrounding system (drives command, RAM data, m_ready).
interface ram_byte_reader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [7:0]            m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  start, base_addr, len, ram_data, m_ready,
    output busy, done, ram_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, base_addr, len, ram_data, m_ready,
    input  busy, done, ram_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ram_byte_reader.sv
// ram_byte_reader: burst read engine for the 16-bit RAM. On start it reads
// len consecutive words from base_addr and emits each as two bytes, low byte
// first, on a valid/ready stream; m_last marks the high byte of the last word.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ram_byte_reader_if.master (command, status, RAM read port, stream)
// All interface outputs are registered; they are computed from the next state
// so that e.g. m_valid is high exactly while the FSM sits in SEND_LO/SEND_HI.
module ram_byte_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  ram_byte_reader_if.master  bus
);

  localparam int unsigned AW     = ADDR_WIDTH;
  localparam int unsigned LW     = ADDR_WIDTH + 1;
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND_LO = 3'd2,
    S_SEND_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q,     state_nxt;
  logic [AW-1:0]     cur_addr_q,  cur_addr_nxt;
  logic [LW-1:0]     remaining_q, remaining_nxt;
  logic [DW-1:0]     word_q,      word_nxt;
  logic [AW-1:0]     ram_addr_q,  ram_addr_nxt;
  logic [BYTE_W-1:0] m_data_q,    m_data_nxt;
  logic              m_last_q,    m_last_nxt;
  logic              m_valid_q,   m_valid_nxt;
  logic              busy_q,      busy_nxt;
  logic              done_q,      done_nxt;
  logic              hs;

  // Stream handshake of the byte currently presented.
  assign hs = m_valid_q & bus.m_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_q;
    cur_addr_nxt  = cur_addr_q;
    remaining_nxt = remaining_q;
    word_nxt      = word_q;
    ram_addr_nxt  = ram_addr_q;
    m_data_nxt    = m_data_q;
    m_last_nxt    = m_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cur_addr_nxt  = bus.base_addr;
          remaining_nxt = bus.len;
          ram_addr_nxt  = bus.base_addr;
          state_nxt     = (bus.len == LW'(0)) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // ram_addr has been stable for a full cycle; capture the word once so
        // later RAM writes cannot disturb the bytes in flight.
        word_nxt   = bus.ram_data;
        m_data_nxt = bus.ram_data[BYTE_W-1:0];
        m_last_nxt = 1'b0;
        state_nxt  = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (hs) begin
          m_data_nxt = word_q[DW-1:BYTE_W];
          m_last_nxt = (remaining_q == LW'(1));
          state_nxt  = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (hs) begin
          m_last_nxt = 1'b0;
          if (remaining_q == LW'(1)) begin
            state_nxt = S_DONE;
          end else begin
            remaining_nxt = remaining_q - LW'(1);
            cur_addr_nxt  = cur_addr_q + AW'(1);
            ram_addr_nxt  = cur_addr_q + AW'(1);
            state_nxt     = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Status and valid follow the state being entered.
    m_valid_nxt = (state_nxt == S_SEND_LO) || (state_nxt == S_SEND_HI);
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = (state_nxt == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      ram_addr_q  <= '0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cur_addr_q  <= cur_addr_nxt;
      remaining_q <= remaining_nxt;
      word_q      <= word_nxt;
      ram_addr_q  <= ram_addr_nxt;
      m_data_q    <= m_data_nxt;
      m_last_q    <= m_last_nxt;
      m_valid_q   <= m_valid_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_byte_reader.sv
// tb_ram_byte_reader: self-checking bench for ram_byte_reader. A behavioural
// RAM array feeds the asynchronous read port; each burst pushes its expected
// {m_last, m_data} bytes into a queue that the scenario tasks pop on every
// stream handshake. Inputs change 1 time unit after the rising edge, outputs
// are sampled on the falling edge.
module tb_ram_byte_reader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_byte_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign bus.ram_data = mem[bus.ram_addr];

  ram_byte_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [8:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  // Issue a start pulse and queue the bytes the burst must produce.
  task automatic go(input logic [AW-1:0] base, input logic [AW:0] n);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    for (int i = 0; i < int'(n); i++) begin
      a = base + AW'(i);
      w = mem[a];
      exp_q.push_back({1'b0, w[7:0]});
      exp_q.push_back({(i == int'(n) - 1), w[15:8]});
    end
    bus.base_addr = base;
    bus.len       = n;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({bus.busy, bus.done, bus.m_valid, bus.m_last, bus.m_data, bus.ram_addr} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=00000",
               {bus.busy, bus.done, bus.m_valid, bus.m_last, bus.m_data, bus.ram_addr});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle got busy=%b valid=%b exp busy=0 valid=0", bus.busy, bus.m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [8:0] e;
    mem[8'h10] = 16'hBEEF;
    mem[8'h11] = 16'h1234;
    bus.m_ready = 1'b1;
    go(8'h10, 9'd2);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (bus.m_valid !== 1'b0 || bus.busy !== 1'b1 || bus.ram_addr !== 8'h10) begin
          n_err++;
          $display("FAIL basic_load got valid=%b busy=%b addr=%h exp 0 1 10",
                   bus.m_valid, bus.busy, bus.ram_addr);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (bus.m_valid !== 1'b1) begin
          n_err++;
          $display("FAIL basic_latency got valid=%b exp 1", bus.m_valid);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.m_last, bus.m_data} !== e) begin
          n_err++;
          $display("FAIL basic_byte got=%h exp=%h", {bus.m_last, bus.m_data}, e);
        end
      end
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL basic_timeout got %0d bytes left exp 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done got done=%b busy=%b valid=%b exp 1 1 0", bus.done, bus.busy, bus.m_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle got done=%b busy=%b exp 0 0", bus.done, bus.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    logic [8:0] prev;
    logic       prev_stall;
    logic [3:0] pat;
    pat = 4'b1001;
    prev = '0;
    prev_stall = 1'b0;
    go(8'h10, 9'd2);
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      bus.m_ready = pat[c % 4];
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++;
        if (bus.m_valid !== 1'b1 || {bus.m_last, bus.m_data} !== prev) begin
          n_err++;
          $display("FAIL bp_stable got valid=%b byte=%h exp valid=1 byte=%h",
                   bus.m_valid, {bus.m_last, bus.m_data}, prev);
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev = {bus.m_last, bus.m_data};
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.m_last, bus.m_data} !== e) begin
          n_err++;
          $display("FAIL bp_byte got=%h exp=%h", {bus.m_last, bus.m_data}, e);
        end
      end
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL bp_timeout got %0d bytes left exp 0", exp_q.size());
      exp_q.delete();
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done got done=%b valid=%b exp 1 0", bus.done, bus.m_valid);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [8:0]    e;
    logic [AW-1:0] ea;
    int            k;
    mem[8'hFF] = 16'hAA55;
    mem[8'h00] = 16'hC3C3;
    bus.m_ready = 1'b1;
    k = 0;
    go(8'hFF, 9'd2);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        e  = exp_q.pop_front();
        ea = 8'hFF + AW'(k / 2);
        k++;
        n_cmp++;
        if ({bus.m_last, bus.m_data} !== e || bus.ram_addr !== ea) begin
          n_err++;
          $display("FAIL wrap_byte got byte=%h addr=%h exp byte=%h addr=%h",
                   {bus.m_last, bus.m_data}, bus.ram_addr, e, ea);
        end
      end
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL wrap_timeout got %0d bytes left exp 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done got done=%b exp 1", bus.done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero();
    go(8'h33, 9'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL len0_done got done=%b busy=%b valid=%b exp 1 1 0", bus.done, bus.busy, bus.m_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL len0_idle got done=%b busy=%b valid=%b exp 0 0 0", bus.done, bus.busy, bus.m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    logic [8:0] e;
    bus.m_ready = 1'b1;
    go(8'h20, 9'd3);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (c == 2 || c == 5) begin
        bus.base_addr = 8'h40;
        bus.len       = 9'd7;
        bus.start     = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.m_last, bus.m_data} !== e) begin
          n_err++;
          $display("FAIL ign_byte got=%h exp=%h", {bus.m_last, bus.m_data}, e);
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL ign_timeout got %0d bytes left exp 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL ign_done got done=%b exp 1", bus.done);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ign_no_restart got busy=%b valid=%b exp 0 0", bus.busy, bus.m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [8:0] e;
    bus.m_ready = 1'b1;
    go(8'h30, 9'd2);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    e = exp_q[1];
    n_cmp++;
    if (bus.m_valid !== 1'b1 || {bus.m_last, bus.m_data} !== e) begin
      n_err++;
      $display("FAIL mrst_in_hi got valid=%b byte=%h exp valid=1 byte=%h",
               bus.m_valid, {bus.m_last, bus.m_data}, e);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.m_valid, bus.m_last, bus.m_data, bus.ram_addr} !== 20'h0) begin
      n_err++;
      $display("FAIL mrst_async got=%h exp=00000",
               {bus.busy, bus.done, bus.m_valid, bus.m_last, bus.m_data, bus.ram_addr});
    end
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    mem[8'h50] = 16'h5A0F;
    go(8'h50, 9'd1);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.m_last, bus.m_data} !== e) begin
          n_err++;
          $display("FAIL mrst_byte got=%h exp=%h", {bus.m_last, bus.m_data}, e);
        end
      end
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL mrst_timeout got %0d bytes left exp 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL mrst_done got done=%b exp 1", bus.done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.m_ready   = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_start_ignored();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
